// File: rtl/pb_debouncer_if.sv
// Push-button debouncer signal bundle.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN (adds glitch_cnt).
// Signals:
//   pb_raw      raw button level, asynchronous to the design clock
//   pb_clean    debounced level
//   pb_busy     high while a candidate transition is being qualified
//   glitch_cnt  saturating count of aborted transitions (macro only)
// Modports: master drives pb_raw (button side), slave is the debouncer.
interface pb_debouncer_if;
    logic       pb_raw;
    logic       pb_clean;
    logic       pb_busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (output pb_raw, input pb_clean, input pb_busy, input glitch_cnt);
    modport slave  (input pb_raw, output pb_clean, output pb_busy, output glitch_cnt);
`else
    modport master (output pb_raw, input pb_clean, input pb_busy);
    modport slave  (input pb_raw, output pb_clean, output pb_busy);
`endif
endinterface

// File: rtl/pb_debouncer.sv
// Synchronises and debounces a raw push-button level into a clean level.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN (saturating glitch counter).
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   pb    pb_debouncer_if.slave: pb_raw in; pb_clean, pb_busy (, glitch_cnt) out
// Parameters:
//   SYNC_STAGES    synchroniser depth (2..4)
//   STABLE_CYCLES  consecutive samples needed to accept a new level
//   CNT_W          stability counter width
module pb_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 20
) (
    input  logic            clk,
    input  logic            rst,
    pb_debouncer_if.slave   pb
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q;
    logic                   busy_q;

    // Synchroniser chain; only its last stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pb.pb_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
            busy_q  <= (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
        end
    end

    // Next-state logic; with a single-sample threshold the WAIT states are skipped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign pb.pb_clean = clean_q;
    assign pb.pb_busy  = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       abort_c;
    logic [7:0] glitch_q;

    // A qualification abandoned because the sample reverted counts as one glitch.
    assign abort_c = ((state_q == ST_WAIT_HIGH) && !s) || ((state_q == ST_WAIT_LOW) && s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (abort_c && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign pb.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_pb_debouncer.sv
// Self-checking bench for pb_debouncer: two instances (STABLE_CYCLES 4 and 1)
// share the clock, reset and raw input, and are compared every cycle against a
// run-length reference model, plus directed latency/glitch checks.
module tb_pb_debouncer;

    localparam int unsigned SYNC = 2;

    logic clk;
    logic rst;

    pb_debouncer_if if4 ();
    pb_debouncer_if if1 ();

    pb_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4), .CNT_W(20)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .pb  (if4.slave)
    );

    pb_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1), .CNT_W(20)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .pb  (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 -> threshold 4, index 1 -> threshold 1.
    int m_stable [2] = '{4, 1};
    int m_clean  [2];
    int m_run    [2];
    int m_glitch [2];
    bit hist [$];
    bit raw_v;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(SYNC); i++) hist.push_back(1'b0);
        for (int i = 0; i < 2; i++) begin
            m_clean[i]  = 0;
            m_run[i]    = 0;
            m_glitch[i] = 0;
        end
    endtask

    // One clock edge: the model sees raw delayed by SYNC edges and counts
    // the run of consecutive samples disagreeing with the accepted level.
    task automatic model_step(input bit raw_now);
        bit s;
        s = hist.pop_front();
        hist.push_back(raw_now);
        for (int i = 0; i < 2; i++) begin
            if (int'(s) != m_clean[i]) begin
                m_run[i]++;
                if (m_run[i] == m_stable[i]) begin
                    m_clean[i] = int'(s);
                    m_run[i]   = 0;
                end
            end else begin
                if (m_run[i] > 0 && m_glitch[i] < 255) m_glitch[i]++;
                m_run[i] = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("clean4", int'(if4.pb_clean), m_clean[0]);
        chk("busy4",  int'(if4.pb_busy),  int'(m_run[0] > 0));
        chk("clean1", int'(if1.pb_clean), m_clean[1]);
        chk("busy1",  int'(if1.pb_busy),  int'(m_run[1] > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch4", int'(if4.glitch_cnt), m_glitch[0]);
        chk("glitch1", int'(if1.glitch_cnt), m_glitch[1]);
`endif
    endtask

    task automatic set_raw(input bit v);
        raw_v      = v;
        if4.pb_raw = v;
        if1.pb_raw = v;
    endtask

    // Advance one edge, update the model, then check 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(raw_v);
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset asserted between edges, checked before any edge.
    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_clean4", int'(if4.pb_clean), 0);
        chk("rst_busy4",  int'(if4.pb_busy),  0);
        chk("rst_clean1", int'(if1.pb_clean), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("rst_glitch4", int'(if4.glitch_cnt), 0);
`endif
        ticks(2);
        rst = 1'b0;
    endtask

    int g0;

    initial begin
        rst = 1'b1;
        set_raw(1'b0);
        model_reset();
        #2;
        ticks(2);
        rst = 1'b0;
        ticks(3);

        // Test 1: mid-qualification reset with raw held high.
        set_raw(1'b1);
        ticks(3);
        chk("t1_busy_pre", int'(if4.pb_busy), 1);
        pulse_reset();
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk("t1_clean4", int'(if4.pb_clean), int'(e >= 5));
            chk("t1_clean1", int'(if1.pb_clean), int'(e >= 2));
        end

        // Test 2: clean press from a settled low level.
        set_raw(1'b0);
        ticks(10);
        set_raw(1'b1);
        for (int e = 0; e < 20; e++) begin
            tick();
            chk("t2_clean4", int'(if4.pb_clean), int'(e >= 5));
            chk("t2_busy4",  int'(if4.pb_busy),  int'(e >= 2 && e <= 4));
            chk("t2_busy1",  int'(if1.pb_busy),  0);
        end

        // Test 3: bounce 1,0,1,0,1 (2 cycles each) then held high.
        set_raw(1'b0);
        ticks(10);
        g0 = m_glitch[0];
        for (int p = 0; p < 4; p++) begin
            set_raw((p % 2) == 0);
            ticks(2);
            chk("t3_clean4_low", int'(if4.pb_clean), 0);
        end
        set_raw(1'b1);
        ticks(3);
        chk("t3_clean4_still_low", int'(if4.pb_clean), 0);
        ticks(8);
        chk("t3_clean4_high", int'(if4.pb_clean), 1);
        chk("t3_glitch_delta", m_glitch[0] - g0, 2);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("t3_glitch4_cnt", int'(if4.glitch_cnt), g0 + 2);
`endif

        // Test 4: release bounce from HIGH.
        set_raw(1'b0);
        ticks(3);
        set_raw(1'b1);
        for (int e = 0; e < 6; e++) begin
            tick();
            chk("t4_clean4_hold", int'(if4.pb_clean), 1);
        end
        set_raw(1'b0);
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk("t4_clean4_fall", int'(if4.pb_clean), int'(e < 5));
        end

        // Test 5: single-cycle pulse through the threshold-1 instance.
        ticks(6);
        set_raw(1'b1);
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e == 0) set_raw(1'b0);
            chk("t5_clean1", int'(if1.pb_clean), int'(e == 2));
            chk("t5_busy1",  int'(if1.pb_busy),  0);
        end

        // Test 6: 300 forced aborts saturate the glitch count; reset clears it.
        ticks(6);
        for (int n = 0; n < 300; n++) begin
            set_raw(1'b1);
            tick();
            set_raw(1'b0);
            tick();
        end
        ticks(6);
        chk("t6_model_sat", m_glitch[0], 255);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("t6_glitch4_sat", int'(if4.glitch_cnt), 255);
        pulse_reset();
        tick();
        chk("t6_glitch4_clr", int'(if4.glitch_cnt), 0);
`else
        pulse_reset();
        tick();
`endif

        // Random hold lengths, mostly short enough to bounce.
        for (int n = 0; n < 600; n++) begin
            set_raw(1'($urandom_range(0, 1)));
            ticks(int'($urandom_range(1, 8)));
        end

        // Random asynchronous reset in the middle of traffic.
        set_raw(1'b1);
        ticks(3);
        #2;
        pulse_reset();
        ticks(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
